fir_coeff_loader: RTL and testbench

Host-side initiator of the FIR coefficient-update protocol. It accepts coefficients over a valid/ready stream, waits until the filter controller is idle, then drives the update flag, RAM address, write data and coefficient count so that the controller writes one word per address into its 4-bank coefficient RAM (bank = address[1:0], word = address[5:2]). It sits between the register/host interface and the FIR controller, and it guarantees that every word is presented for at least one cycle while the controller is in its write state.

---
 rtl/fir_pkg.sv | 46 ++++
 rtl/fir_coeff_loader.sv | 214 +++++++++++++++++++++
 tb/tb_fir_coeff_loader.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared definitions for the FIR coefficient-update path:
//               loader state encoding, default widths, coefficient RAM
//               bank/word split and small address helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Default widths used by the coefficient loader
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 16;

  // Width of the coefficient-count field
  localparam int NUM_W      = 6;

  // Coefficient RAM organisation: bank = addr[1:0], word = addr[5:2]
  localparam int BANK_LSB   = 0;
  localparam int BANK_W     = 2;
  localparam int WORD_LSB   = 2;
  localparam int WORD_W     = 4;

  localparam int MAX_COEFF  = 63;

  // Loader state encoding
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FIRST   = 3'd1,
    ST_ARM     = 3'd2,
    ST_SYNC    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_RELEASE = 3'd6
  } fir_ld_state_t;

  function automatic logic [BANK_W-1:0] bank_of(input logic [DEF_ADDR_W-1:0] addr);
    return addr[BANK_LSB +: BANK_W];
  endfunction

  function automatic logic [WORD_W-1:0] word_of(input logic [DEF_ADDR_W-1:0] addr);
    return addr[WORD_LSB +: WORD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : fir_coeff_loader
// Description : Host-side initiator of the FIR coefficient-update protocol.
//               Accepts N coefficients over a valid/ready stream, waits for
//               the filter controller to be idle, then raises the update flag
//               and presents one word per address so the controller writes
//               each of them at least once while in its write state.
//
// Ports       : iClk12M          - clock
//               iRst             - synchronous active-high reset
//               iStart           - one-cycle update request
//               iNumOfCoeff      - coefficient count N, sampled on iStart
//               iCoeffValid/iCoeff/oCoeffReady - host word stream
//               iFirIdle         - controller is in IDLE or WREND
//               oCoeffUpdateFlag - update flag to the controller
//               oAddrRam/oWrDtRam - presented address and word
//               oNumOfCoeff      - latched N
//               oBusy/oDone/oErr - status (done/err are one-cycle pulses)
//
// Options     : FIR_COEFF_LOADER_TIMEOUT_EN - when defined, a host stall of
//               TIMEOUT_CYCLES consecutive ready cycles aborts the update
//               (oErr pulse, flag released, no oDone).
// Revision    : 1.0 - initial release
// ============================================================================
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              iClk12M,
  input  logic              iRst,
  input  logic              iStart,
  input  logic [NUM_W-1:0]  iNumOfCoeff,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeff,
  output logic              oCoeffReady,
  input  logic              iFirIdle,
  output logic              oCoeffUpdateFlag,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic [NUM_W-1:0]  oNumOfCoeff,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam logic [NUM_W-1:0]  IDX_ONE  = NUM_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  fir_ld_state_t     state, state_nxt;

  logic              ready_q, ready_nxt;
  logic              flag_q, flag_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] data_q, data_nxt;
  logic [NUM_W-1:0]  num_q, num_nxt;
  logic [NUM_W-1:0]  idx_q, idx_nxt;   // index of the word currently presented
  logic [NUM_W-1:0]  last_idx;
  logic              xfer;
  logic              timeout_hit;

  // ready_q is high exactly in FIRST and WRITE, so it doubles as the
  // "loader wants a word" qualifier for the handshake.
  assign xfer     = iCoeffValid && ready_q;
  assign last_idx = num_q - IDX_ONE;

`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
  logic [7:0] stall_cnt;
  logic       stall_cyc;

  // Only consecutive stalled ready cycles count; any valid cycle (which in
  // FIRST/WRITE is a transfer) or any other state clears the counter.
  assign stall_cyc   = ready_q && !iCoeffValid;
  assign timeout_hit = stall_cyc && (stall_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge iClk12M) begin
    if (iRst || !stall_cyc) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      num_q   <= '0;
      idx_q   <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
      flag_q  <= flag_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      num_q   <= num_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Next state and next output values
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    addr_nxt  = addr_q;
    data_nxt  = data_q;
    num_nxt   = num_q;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (iStart) begin
          if (iNumOfCoeff == '0) begin
            err_nxt = 1'b1;
          end else begin
            num_nxt   = iNumOfCoeff;
            state_nxt = ST_FIRST;
          end
        end
      end

      // Word 0 is registered while the flag is still low, so the controller
      // never sees a stale word at address 0.
      ST_FIRST: begin
        if (xfer) begin
          idx_nxt   = '0;
          addr_nxt  = '0;
          data_nxt  = iCoeff;
          state_nxt = ST_ARM;
        end
      end

      ST_ARM: begin
        if (iFirIdle) begin
          state_nxt = ST_SYNC;
        end
      end

      // One flag cycle without a new word lets the controller enter its
      // write state while word 0 is on the bus.
      ST_SYNC: begin
        state_nxt = (num_q == IDX_ONE) ? ST_DRAIN : ST_WRITE;
      end

      ST_WRITE: begin
        if (xfer) begin
          idx_nxt  = idx_q + IDX_ONE;
          addr_nxt = addr_q + ADDR_ONE;
          data_nxt = iCoeff;
          if (idx_nxt == last_idx) begin
            state_nxt = ST_DRAIN;
          end
        end
      end

      // Keeps the flag up one more cycle so the last word gets written.
      ST_DRAIN: begin
        state_nxt = ST_RELEASE;
        done_nxt  = 1'b1;
      end

      ST_RELEASE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (timeout_hit) begin
      state_nxt = ST_RELEASE;
      err_nxt   = 1'b1;
    end

    ready_nxt = (state_nxt == ST_FIRST) || (state_nxt == ST_WRITE);
    flag_nxt  = (state_nxt == ST_SYNC) || (state_nxt == ST_WRITE) ||
                (state_nxt == ST_DRAIN);
    busy_nxt  = (state_nxt != ST_IDLE);
  end

  assign oCoeffReady      = ready_q;
  assign oCoeffUpdateFlag = flag_q;
  assign oAddrRam         = addr_q;
  assign oWrDtRam         = data_q;
  assign oNumOfCoeff      = num_q;
  assign oBusy            = busy_q;
  assign oDone            = done_q;
  assign oErr             = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_coeff_loader
// Description : Self-checking bench for fir_coeff_loader. A table of update
//               scenarios plus randomized updates are driven through a host
//               model; a controller/RAM model captures every word presented
//               under the flag and the results are compared against values
//               derived from the protocol timing rules.
//               FIR_COEFF_LOADER_TIMEOUT_EN adds the host-stall abort case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_loader;

  logic        clk;
  logic        iRst;
  logic        iStart;
  logic [5:0]  iNumOfCoeff;
  logic        iCoeffValid;
  logic [15:0] iCoeff;
  logic        oCoeffReady;
  logic        iFirIdle;
  logic        oCoeffUpdateFlag;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  fir_coeff_loader #(
    .ADDR_W        (6),
    .DATA_W        (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .iClk12M         (clk),
    .iRst            (iRst),
    .iStart          (iStart),
    .iNumOfCoeff     (iNumOfCoeff),
    .iCoeffValid     (iCoeffValid),
    .iCoeff          (iCoeff),
    .oCoeffReady     (oCoeffReady),
    .iFirIdle        (iFirIdle),
    .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oAddrRam        (oAddrRam),
    .oWrDtRam        (oWrDtRam),
    .oNumOfCoeff     (oNumOfCoeff),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oErr            (oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One update scenario and its expected outcome.
  // exp_lat: negedge samples after the iStart edge until oDone is seen.
  typedef struct {
    int n;
    int base;
    int step;
    int idle_delay;
    int drop_at;     // host index at which valid is withdrawn
    int drop_len;
    int poke_n;      // nonzero: pulse iStart with this N while busy
    bit expect_to;
    int exp_lat;
    int exp_flag;
  } vec_t;

  function automatic vec_t mk(input int n, input int base, input int step,
                              input int idle_delay, input int drop_at,
                              input int drop_len, input int poke_n,
                              input bit expect_to, input int exp_lat,
                              input int exp_flag);
    vec_t v;
    v.n = n; v.base = base; v.step = step; v.idle_delay = idle_delay;
    v.drop_at = drop_at; v.drop_len = drop_len; v.poke_n = poke_n;
    v.expect_to = expect_to; v.exp_lat = exp_lat; v.exp_flag = exp_flag;
    return v;
  endfunction

  task automatic run_update(input vec_t v, input bit rnd);
    logic [15:0] words [64];
    logic [15:0] ram   [64];
    int          hold  [64];
    bit          seen  [64];
    int host_idx = 0, stalls = 0, flag_stalls = 0, flag_cyc = 0, arm_cyc = 0;
    int done_cnt = 0, err_cnt = 0, done_at = -1, idle_left = 0, drop_left = 0;
    int consec = 0, bad_addr = 0, ram_bad = 0, exp_lat, exp_flag;
    bit ready_prev = 1'b0, w0_done = 1'b0, flag_seen = 1'b0, finished = 1'b0;

    for (int k = 0; k < 64; k++) begin
      words[k] = rnd ? 16'($urandom) : 16'(v.base + v.step * k);
      ram[k]   = '0;
      hold[k]  = 0;
      seen[k]  = 1'b0;
    end

    @(negedge clk);
    iStart      = 1'b1;
    iNumOfCoeff = 6'(v.n);
    iCoeffValid = 1'b0;
    iFirIdle    = 1'b1;

    for (int cyc = 1; cyc <= 600 && !finished; cyc++) begin
      @(negedge clk);
      // Transfer on the edge just passed?
      if (iCoeffValid && ready_prev) begin
        host_idx++;
        if (host_idx == 1) begin
          w0_done   = 1'b1;
          idle_left = v.idle_delay;
        end
        if (host_idx == v.drop_at) drop_left = v.drop_len;
      end
      // Controller model: writes whatever is presented while the flag is up
      if (oCoeffUpdateFlag) begin
        flag_cyc++;
        flag_seen = 1'b1;
        if (int'(oAddrRam) < v.n) begin
          ram[oAddrRam]  = oWrDtRam;
          seen[oAddrRam] = 1'b1;
          hold[oAddrRam]++;
        end else begin
          bad_addr++;
        end
      end else if (w0_done && !flag_seen && oBusy && !oCoeffReady && !oDone && !oErr) begin
        arm_cyc++;
      end
      if (done_at >= 0 && cyc == done_at + 1) begin
        check("busy_drop", int'(oBusy), 0);
        check("single_pulse", int'(oDone | oErr), 0);
        finished = 1'b1;
      end
      if (oDone) begin
        done_cnt++;
        if (done_at < 0) done_at = cyc;
      end
      if (oErr) begin
        err_cnt++;
        if (done_at < 0) done_at = cyc;
        check("flag_low_on_err", int'(oCoeffUpdateFlag), 0);
      end

      // Drive next cycle
      iStart = (v.poke_n != 0 && cyc == 3);
      if (iStart) iNumOfCoeff = 6'(v.poke_n);
      if (w0_done) begin
        iFirIdle = (idle_left == 0);
        if (idle_left > 0) idle_left--;
      end
      if (host_idx < v.n) begin
        iCoeff = words[host_idx];
        if (drop_left > 0) begin
          iCoeffValid = 1'b0;
          drop_left--;
        end else if (rnd && consec < 2 && $urandom_range(0, 99) < 30) begin
          iCoeffValid = 1'b0;
          consec++;
        end else begin
          iCoeffValid = 1'b1;
          consec = 0;
        end
      end else begin
        iCoeffValid = 1'b0;
      end
      if (oCoeffReady && !iCoeffValid) begin
        stalls++;
        if (oCoeffUpdateFlag) flag_stalls++;
      end
      ready_prev = oCoeffReady;
    end

    iStart = 1'b0;
    if (!finished) check("update_completed", 0, 1);

    if (v.expect_to) begin
      check("timeout_err", err_cnt, 1);
      check("timeout_no_done", done_cnt, 0);
    end else begin
      exp_lat  = rnd ? v.n + 4 + v.idle_delay + stalls : v.exp_lat;
      exp_flag = rnd ? v.n + 1 + flag_stalls : v.exp_flag;
      for (int k = 0; k < v.n; k++) begin
        if (!seen[k] || ram[k] !== words[k]) ram_bad++;
      end
      check("done_count", done_cnt, 1);
      check("err_count", err_cnt, 0);
      check("done_latency", done_at, exp_lat);
      check("flag_cycles", flag_cyc, exp_flag);
      check("arm_cycles", arm_cyc, v.idle_delay + 1);
      check("ram_contents", ram_bad, 0);
      check("addr_range", bad_addr, 0);
      check("num_latched", int'(oNumOfCoeff), v.n);
      if (v.drop_len > 0) check("held_word_cycles", hold[v.drop_at - 1], v.drop_len + 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, int'({oCoeffReady, oCoeffUpdateFlag, oBusy, oDone, oErr}), 0);
    check({tag, "_addr"}, int'(oAddrRam), 0);
    check({tag, "_data"}, int'(oWrDtRam), 0);
    check({tag, "_num"}, int'(oNumOfCoeff), 0);
  endtask

  vec_t table_v [7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   last_n;
    bit   hit;

    //               n   base     step     idle drop len poke to  lat flag
    table_v[0] = mk(4,  'h0011, 'h0011,  0,   0,  0,  0,   0,  8,  5);
    table_v[1] = mk(1,  'h7FFF, 0,       0,   0,  0,  0,   0,  5,  2);
    table_v[2] = mk(3,  'h0123, 'h0100,  10,  0,  0,  0,   0,  17, 4);
    table_v[3] = mk(63, 'h8000, 1,       0,   0,  0,  0,   0,  67, 64);
    table_v[4] = mk(8,  'h0100, 'h0101,  0,   5,  3,  0,   0,  15, 12);
    table_v[5] = mk(5,  'h0A0A, 3,       0,   0,  0,  9,   0,  9,  6);
    table_v[6] = mk(2,  'hFFFF, 'hFFFF,  2,   0,  0,  0,   0,  8,  3);

    iRst = 1'b1; iStart = 1'b0; iNumOfCoeff = '0;
    iCoeffValid = 1'b0; iCoeff = '0; iFirIdle = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    iRst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    for (int i = 0; i < 7; i++) run_update(table_v[i], 1'b0);
    last_n = table_v[6].n;

    // N = 0 is rejected: one oErr pulse, no flag, N unchanged
    @(negedge clk);
    iStart = 1'b1; iNumOfCoeff = 6'd0;
    @(negedge clk);
    iStart = 1'b0;
    check("n0_err", int'(oErr), 1);
    check("n0_flag", int'(oCoeffUpdateFlag), 0);
    check("n0_busy", int'(oBusy), 0);
    check("n0_num_hold", int'(oNumOfCoeff), last_n);
    @(negedge clk);
    check("n0_err_pulse", int'(oErr), 0);

    // Reset in the middle of WRITE at address 5
    @(negedge clk);
    iStart = 1'b1; iNumOfCoeff = 6'd8; iCoeffValid = 1'b1; iCoeff = 16'h5A5A;
    @(negedge clk);
    iStart = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge clk);
      if (oCoeffUpdateFlag && oAddrRam == 6'd5) hit = 1'b1;
    end
    check("reached_addr5", int'(hit), 1);
    iRst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    iRst = 1'b0; iCoeffValid = 1'b0;
    run_update(mk(3, 'h0BAD, 1, 0, 0, 0, 0, 0, 7, 4), 1'b0);

    // Randomized updates
    for (int r = 0; r < 8; r++) begin
      v = mk($urandom_range(1, 63), 0, 0, $urandom_range(0, 3), 0, 0, 0, 0, 0, 0);
      run_update(v, 1'b1);
    end

`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
    // Four-cycle host stall after word 4 aborts the update
    run_update(mk(8, 'h1000, 1, 0, 5, 4, 0, 1, 0, 0), 1'b0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
